// File: rtl/mnist_seq_pkg.sv
// rtl/mnist_seq_pkg.sv - shared types and helpers for the MNIST inference sequencer
package mnist_seq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int CLS_W = 4;

  // NaR is the pattern with only the sign bit set
  function automatic int unsigned nar_value(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/mnist_inference_sequencer_argmax.sv
// rtl/mnist_inference_sequencer_argmax.sv - streaming signed-posit argmax tracker
// idx/score present the best so far including the element currently offered.
module posit_argmax
  import mnist_seq_pkg::*;
#(
  parameter int POSIT_WIDTH = 4,
  parameter int IDX_W = CLS_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   valid,
  input  logic [POSIT_WIDTH-1:0] data,
  output logic [IDX_W-1:0]       idx,
  output logic [POSIT_WIDTH-1:0] score
);

  localparam logic [POSIT_WIDTH-1:0] NAR = POSIT_WIDTH'(nar_value(POSIT_WIDTH));

  logic [IDX_W-1:0]       cur_idx;
  logic [IDX_W-1:0]       best_idx;
  logic [POSIT_WIDTH-1:0] best_score;
  logic                   better;

  // Strict compare keeps the lower index on ties; NaR never wins over a real value
  always_comb begin
    better = (data != NAR) &&
             ((best_score == NAR) || ($signed(data) > $signed(best_score)));
    idx    = start ? '0 : (better ? cur_idx : best_idx);
    score  = (start || better) ? data : best_score;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_idx    <= '0;
      best_idx   <= '0;
      best_score <= '0;
    end else if (valid) begin
      best_idx   <= idx;
      best_score <= score;
      cur_idx    <= start ? IDX_W'(1) : cur_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/mnist_inference_sequencer.sv
// rtl/mnist_inference_sequencer.sv - job admission, credit throttling and argmax classification
module mnist_inference_sequencer
  import mnist_seq_pkg::*;
#(
  parameter int IN_W          = 8,
  parameter int POSIT_WIDTH   = 4,
  parameter int WORDS_PER_PIC = 392,
  parameter int NB_CLASSES    = 10,
  parameter int PICS_W        = 8,
  parameter int MAX_INFLIGHT  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_start,
  input  logic [PICS_W-1:0]      cfg_nb_pics,
  output logic                   busy_o,
  output logic                   done_o,
  input  logic                   src_rts_i,
  output logic                   src_rtr_o,
  input  logic [IN_W-1:0]        src_data_i,
  output logic                   dn_rts_o,
  input  logic                   dn_rtr_i,
  output logic                   dn_eow_o,
  output logic [IN_W-1:0]        dn_data_o,
  input  logic                   res_rts_i,
  output logic                   res_rtr_o,
  input  logic                   res_eow_i,
  input  logic [POSIT_WIDTH-1:0] res_posit_i,
  output logic                   class_valid_o,
  output logic [3:0]             class_o,
  output logic [POSIT_WIDTH-1:0] class_score_o,
  output logic [PICS_W-1:0]      pic_idx_o,
  output logic                   err_o
);

  localparam int WC_W = $clog2(WORDS_PER_PIC);
  localparam int IF_W = $clog2(MAX_INFLIGHT + 1);

  state_t                 state;
  logic [PICS_W-1:0]      nb_pics, admitted, classified;
  logic [WC_W-1:0]        word_cnt;
  logic [IF_W-1:0]        inflight;
  logic [CLS_W-1:0]       cls_cnt, best_idx;
  logic [POSIT_WIDTH-1:0] best_score;
  logic gate, xfer, last_word, admit, res_xfer, last_res, classify;

  // Credit only blocks the first word of a picture, never a picture already started
  assign gate      = (state == RUN) && ((word_cnt != '0) || (inflight < IF_W'(MAX_INFLIGHT)));
  assign dn_rts_o  = src_rts_i & gate;
  assign src_rtr_o = dn_rtr_i & gate;
  assign dn_data_o = src_data_i;
  assign xfer      = dn_rts_o & dn_rtr_i;
  assign last_word = (word_cnt == WC_W'(WORDS_PER_PIC - 1));
  assign dn_eow_o  = dn_rts_o & last_word;
  assign admit     = xfer & last_word;
  assign res_xfer  = res_rts_i & res_rtr_o;
  assign last_res  = (cls_cnt == CLS_W'(NB_CLASSES - 1));
  assign classify  = res_xfer & last_res;

  posit_argmax #(.POSIT_WIDTH(POSIT_WIDTH), .IDX_W(CLS_W)) u_argmax (
    .clk   (clk),
    .rst   (rst),
    .start (cls_cnt == '0),
    .valid (res_xfer),
    .data  (res_posit_i),
    .idx   (best_idx),
    .score (best_score)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      res_rtr_o     <= 1'b0;
      nb_pics       <= '0;
      admitted      <= '0;
      classified    <= '0;
      word_cnt      <= '0;
      inflight      <= '0;
      cls_cnt       <= '0;
      class_valid_o <= 1'b0;
      class_o       <= '0;
      class_score_o <= '0;
      pic_idx_o     <= '0;
      err_o         <= 1'b0;
    end else begin
      class_valid_o <= 1'b0;
      done_o        <= 1'b0;
      if (xfer) word_cnt <= last_word ? '0 : word_cnt + WC_W'(1);
      if (admit) admitted <= admitted + PICS_W'(1);
      if (admit && !classify) inflight <= inflight + IF_W'(1);
      if (!admit && classify) inflight <= inflight - IF_W'(1);
      if (res_xfer) begin
        cls_cnt <= last_res ? '0 : cls_cnt + CLS_W'(1);
        if (res_eow_i != last_res) err_o <= 1'b1;
      end
      if (classify) begin
        class_valid_o <= 1'b1;
        class_o       <= best_idx;
        class_score_o <= best_score;
        pic_idx_o     <= classified;
        classified    <= classified + PICS_W'(1);
      end
      case (state)
        IDLE: if (cfg_start) begin
          nb_pics    <= cfg_nb_pics;
          admitted   <= '0;
          classified <= '0;
          word_cnt   <= '0;
          inflight   <= '0;
          cls_cnt    <= '0;
          err_o      <= 1'b0;
          if (cfg_nb_pics == '0) begin
            state  <= DONE;
            done_o <= 1'b1;
          end else begin
            state     <= RUN;
            busy_o    <= 1'b1;
            res_rtr_o <= 1'b1;
          end
        end
        // Leave RUN on the last admission so no stray word slips in
        RUN: if (admit && (admitted + PICS_W'(1) == nb_pics)) state <= DRAIN;
        DRAIN: if (classified == nb_pics) begin
          state     <= DONE;
          busy_o    <= 1'b0;
          res_rtr_o <= 1'b0;
          done_o    <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mnist_inference_sequencer.sv
// tb/tb_mnist_inference_sequencer.sv - directed self-checking bench for the inference sequencer
module tb_mnist_inference_sequencer;

  logic       clk = 1'b0;
  logic       rst, cfg_start;
  logic [7:0] cfg_nb_pics;
  logic       busy_o, done_o;
  logic       src_rts_i, src_rtr_o;
  logic [7:0] src_data_i;
  logic       dn_rts_o, dn_rtr_i, dn_eow_o;
  logic [7:0] dn_data_o;
  logic       res_rts_i, res_rtr_o, res_eow_i;
  logic [3:0] res_posit_i;
  logic       class_valid_o;
  logic [3:0] class_o, class_score_o;
  logic [7:0] pic_idx_o;
  logic       err_o;

  int n_checks = 0;
  int n_fail = 0;

  localparam logic [39:0] VEC_A   = 40'h0147507231;  // 1,3,2,7,0,5,7,4,1,0
  localparam logic [39:0] VEC_NAR = 40'h888F888888;  // NaR everywhere, 0xF at 6
  localparam logic [39:0] VEC_B   = 40'h45F0663812;  // 2,1,8,3,6,6,0,F,5,4

  always #5 clk = ~clk;

  mnist_inference_sequencer dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_nb_pics(cfg_nb_pics),
    .busy_o(busy_o), .done_o(done_o),
    .src_rts_i(src_rts_i), .src_rtr_o(src_rtr_o), .src_data_i(src_data_i),
    .dn_rts_o(dn_rts_o), .dn_rtr_i(dn_rtr_i), .dn_eow_o(dn_eow_o), .dn_data_o(dn_data_o),
    .res_rts_i(res_rts_i), .res_rtr_o(res_rtr_o), .res_eow_i(res_eow_i), .res_posit_i(res_posit_i),
    .class_valid_o(class_valid_o), .class_o(class_o), .class_score_o(class_score_o),
    .pic_idx_o(pic_idx_o), .err_o(err_o)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [7:0] n);
    cfg_start = 1'b1;
    cfg_nb_pics = n;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic feed(input int max_cycles, input int max_xfers,
                      output int xfers, output int eows, output int eow_at, output int bad);
    xfers = 0; eows = 0; eow_at = 0; bad = 0;
    src_rts_i = 1'b1;
    dn_rtr_i = 1'b1;
    for (int c = 0; c < max_cycles && xfers < max_xfers; c++) begin
      src_data_i = 8'(c * 7 + 3);
      #1;
      if (dn_rts_o && dn_rtr_i) begin
        xfers++;
        if (dn_eow_o) begin
          eows++;
          eow_at = xfers;
        end
        if (dn_data_o !== src_data_i) bad++;
      end
      tick();
    end
    src_rts_i = 1'b0;
  endtask

  task automatic send_results(input logic [39:0] v, input int eow_pos, output int not_ready);
    not_ready = 0;
    for (int i = 0; i < 10; i++) begin
      res_rts_i = 1'b1;
      res_posit_i = v[i*4 +: 4];
      res_eow_i = (i == eow_pos);
      #1;
      if (res_rtr_o !== 1'b1) not_ready++;
      tick();
    end
    res_rts_i = 1'b0;
    res_eow_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_start = 1'b0; cfg_nb_pics = '0;
    src_rts_i = 1'b1; dn_rtr_i = 1'b1; src_data_i = 8'hA5;
    res_rts_i = 1'b0; res_eow_i = 1'b0; res_posit_i = '0;
    tick(); tick();
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done_o); end
    n_checks++; if ({src_rtr_o, dn_rts_o, dn_eow_o, res_rtr_o} !== 4'b0) begin n_fail++; $display("FAIL reset_handshake: got %b want 0000", {src_rtr_o, dn_rts_o, dn_eow_o, res_rtr_o}); end
    n_checks++; if ({class_valid_o, class_o, class_score_o, pic_idx_o, err_o} !== 18'b0) begin n_fail++; $display("FAIL reset_class: got %h want 0", {class_valid_o, class_o, class_score_o, pic_idx_o, err_o}); end
    n_checks++; if (dn_data_o !== 8'hA5) begin n_fail++; $display("FAIL reset_data_pass: got %h want a5", dn_data_o); end
    rst = 1'b0; src_rts_i = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int x, e, ea, b, nr;
    start_job(8'd1);
    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", busy_o); end
    feed(450, 10000, x, e, ea, b);
    n_checks++; if (x !== 392) begin n_fail++; $display("FAIL single_xfers: got %0d want 392", x); end
    n_checks++; if (e !== 1 || ea !== 392) begin n_fail++; $display("FAIL single_eow: got %0d at %0d want 1 at 392", e, ea); end
    n_checks++; if (b !== 0) begin n_fail++; $display("FAIL single_data: got %0d bad words want 0", b); end
    send_results(VEC_A, 9, nr);
    n_checks++; if (nr !== 0) begin n_fail++; $display("FAIL single_res_rtr: got %0d stalls want 0", nr); end
    n_checks++; if (class_valid_o !== 1'b1 || class_o !== 4'd3 || class_score_o !== 4'h7 || pic_idx_o !== 8'd0)
      begin n_fail++; $display("FAIL single_class: got v%b c%0d s%h p%0d want v1 c3 s7 p0", class_valid_o, class_o, class_score_o, pic_idx_o); end
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL single_done_early: got %b want 0", done_o); end
    tick();
    n_checks++; if (done_o !== 1'b1 || class_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_done: got d%b v%b want d1 v0", done_o, class_valid_o); end
    tick();
    n_checks++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL single_idle: got d%b b%b want d0 b0", done_o, busy_o); end
  endtask

  task automatic test_nar();
    int x, e, ea, b, nr;
    start_job(8'd1);
    feed(450, 10000, x, e, ea, b);
    send_results(VEC_NAR, 9, nr);
    n_checks++; if (class_valid_o !== 1'b1 || class_o !== 4'd6 || class_score_o !== 4'hF)
      begin n_fail++; $display("FAIL nar_class: got v%b c%0d s%h want v1 c6 sf", class_valid_o, class_o, class_score_o); end
    tick(); tick();
  endtask

  task automatic test_eow_err();
    int x, e, ea, b, nr;
    start_job(8'd1);
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL err_initial: got %b want 0", err_o); end
    feed(450, 10000, x, e, ea, b);
    send_results(VEC_A, 4, nr);
    n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b want 1", err_o); end
    n_checks++; if (class_valid_o !== 1'b1 || class_o !== 4'd3) begin n_fail++; $display("FAIL err_class: got v%b c%0d want v1 c3", class_valid_o, class_o); end
    tick(); tick();
    n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", err_o); end
  endtask

  task automatic test_credit();
    int x, e, ea, b, nr;
    start_job(8'd3);
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL credit_err_clear: got %b want 0", err_o); end
    feed(1000, 10000, x, e, ea, b);
    n_checks++; if (x !== 784 || e !== 2) begin n_fail++; $display("FAIL credit_block: got %0d xfers %0d eow want 784 2", x, e); end
    n_checks++; if (src_rtr_o !== 1'b0) begin n_fail++; $display("FAIL credit_rtr_low: got %b want 0", src_rtr_o); end
    send_results(VEC_B, 9, nr);
    n_checks++; if (class_valid_o !== 1'b1 || class_o !== 4'd4 || class_score_o !== 4'h6 || pic_idx_o !== 8'd0)
      begin n_fail++; $display("FAIL credit_pic0: got v%b c%0d s%h p%0d want v1 c4 s6 p0", class_valid_o, class_o, class_score_o, pic_idx_o); end
    n_checks++; if (src_rtr_o !== 1'b1) begin n_fail++; $display("FAIL credit_reopen: got %b want 1", src_rtr_o); end
    feed(500, 10000, x, e, ea, b);
    n_checks++; if (x !== 392 || e !== 1 || ea !== 392) begin n_fail++; $display("FAIL credit_pic2: got %0d xfers eow %0d at %0d want 392 1 392", x, e, ea); end
    send_results(VEC_A, 9, nr);
    n_checks++; if (class_o !== 4'd3 || pic_idx_o !== 8'd1) begin n_fail++; $display("FAIL credit_pic1: got c%0d p%0d want c3 p1", class_o, pic_idx_o); end
    tick();
    n_checks++; if (done_o !== 1'b0 || busy_o !== 1'b1) begin n_fail++; $display("FAIL credit_not_done: got d%b b%b want d0 b1", done_o, busy_o); end
    send_results(VEC_NAR, 9, nr);
    n_checks++; if (class_valid_o !== 1'b1 || class_o !== 4'd6 || pic_idx_o !== 8'd2) begin n_fail++; $display("FAIL credit_pic2_class: got v%b c%0d p%0d want v1 c6 p2", class_valid_o, class_o, pic_idx_o); end
    tick();
    n_checks++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL credit_done: got %b want 1", done_o); end
    tick();
  endtask

  task automatic test_zero_and_ignore();
    int x, e, ea, b, nr, total;
    start_job(8'd0);
    n_checks++; if (done_o !== 1'b1 || busy_o !== 1'b0 || src_rtr_o !== 1'b0) begin n_fail++; $display("FAIL zero_done: got d%b b%b r%b want d1 b0 r0", done_o, busy_o, src_rtr_o); end
    tick();
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL zero_pulse: got %b want 0", done_o); end
    start_job(8'd1);
    feed(300, 200, x, e, ea, b);
    total = x;
    start_job(8'd5);
    feed(600, 10000, x, e, ea, b);
    total += x;
    n_checks++; if (total !== 392 || e !== 1 || ea !== 192) begin n_fail++; $display("FAIL ignore_start: got %0d xfers eow at %0d want 392 at 192", total, ea); end
    send_results(VEC_A, 9, nr);
    tick();
    n_checks++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL ignore_done: got %b want 1", done_o); end
    tick();
  endtask

  task automatic test_reset_mid();
    int x, e, ea, b, nr;
    start_job(8'd1);
    feed(300, 199, x, e, ea, b);
    rst = 1'b1;
    src_rts_i = 1'b1;
    tick();
    n_checks++; if ({busy_o, src_rtr_o, dn_rts_o, res_rtr_o, done_o} !== 5'b0) begin n_fail++; $display("FAIL mid_reset: got %b want 00000", {busy_o, src_rtr_o, dn_rts_o, res_rtr_o, done_o}); end
    rst = 1'b0;
    src_rts_i = 1'b0;
    tick();
    start_job(8'd1);
    feed(500, 10000, x, e, ea, b);
    n_checks++; if (x !== 392 || e !== 1 || ea !== 392) begin n_fail++; $display("FAIL mid_restart: got %0d xfers eow %0d at %0d want 392 1 392", x, e, ea); end
    send_results(VEC_B, 9, nr);
    n_checks++; if (class_o !== 4'd4 || pic_idx_o !== 8'd0) begin n_fail++; $display("FAIL mid_class: got c%0d p%0d want c4 p0", class_o, pic_idx_o); end
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_nar();
    test_eow_err();
    test_credit();
    test_zero_and_ignore();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mnist_inference_sequencer.md
Name: mnist_inference_sequencer

Overview:
Job controller in front of and behind the MNIST positron pipeline (stream source -> width down-converter -> hidden layer -> output layer). On a start command it admits a programmed number of pictures into the pipeline and marks each picture's last word with eow. It throttles admission by an in-flight picture credit. It collects the 10 output posits per picture and classifies each picture by signed-posit argmax.

Parameters:
IN_W, 8, input stream word width (two 4-bit posits per word)
POSIT_WIDTH, 4, width of posits returned by the output layer
WORDS_PER_PIC, 392, input words per picture (784 posits / 2)
NB_CLASSES, 10, output posits per picture
PICS_W, 8, width of picture counters and of cfg_nb_pics
MAX_INFLIGHT, 2, maximum pictures admitted but not yet classified

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-high reset
cfg_start  in  1  one-cycle job start pulse
cfg_nb_pics  in  PICS_W  pictures in the job; sampled when cfg_start is accepted
busy_o  out  1  job in progress
done_o  out  1  one-cycle pulse when the job completes
src_rts_i  in  1  upstream word valid
src_rtr_o  out  1  ready to upstream
src_data_i  in  IN_W  upstream word
dn_rts_o  out  1  word valid toward the down-converter
dn_rtr_i  in  1  down-converter ready
dn_eow_o  out  1  last word of a picture
dn_data_o  out  IN_W  word toward the down-converter
res_rts_i  in  1  output-layer posit valid
res_rtr_o  out  1  ready to the output layer
res_eow_i  in  1  output layer's end-of-window flag
res_posit_i  in  POSIT_WIDTH  output-layer posit
class_valid_o  out  1  one-cycle classification pulse
class_o  out  4  argmax index, 0..9
class_score_o  out  POSIT_WIDTH  winning posit
pic_idx_o  out  PICS_W  index of the classified picture
err_o  out  1  sticky eow-misalignment flag; cleared by rst or an accepted start

Behaviour:
- Reset: state IDLE; all counters 0; every output 0, except dn_data_o, which follows src_data_i.
- FSM states:
  - IDLE -> RUN on cfg_start when cfg_nb_pics != 0.
  - IDLE -> DONE on cfg_start when cfg_nb_pics == 0.
  - RUN -> DRAIN when the admitted-picture count reaches nb_pics.
  - DRAIN -> DONE when the classified count reaches nb_pics.
  - DONE -> IDLE unconditionally.
  - done_o = 1 only while in DONE.
  - busy_o = 1 in RUN and DRAIN.
  - cfg_start outside IDLE is ignored.
- Input gating is combinational, zero latency:
  - gate = (state==RUN) && (inflight < MAX_INFLIGHT).
  - dn_rts_o = src_rts_i & gate.
  - src_rtr_o = dn_rtr_i & gate.
  - dn_data_o = src_data_i.
- An input transfer is dn_rts_o & dn_rtr_i.
  - word_cnt increments on each transfer and wraps to 0 after WORDS_PER_PIC-1.
  - dn_eow_o = dn_rts_o & (word_cnt == WORDS_PER_PIC-1).
  - The picture is admitted on the eow transfer: admitted++ and inflight++.
  - src_eow_i is not used; the picture boundary is defined by the count.
- Picture admission is not an atomic credit:
  - Once the first word of a picture transfers, that picture's remaining words are not blocked by credit.
  - gate ignores the inflight limit while word_cnt != 0.
- Result side:
  - res_rtr_o = 1 in RUN and DRAIN, 0 otherwise.
  - A result transfer is res_rts_i & res_rtr_o.
  - cls_cnt counts 0..NB_CLASSES-1.
- Argmax:
  - Posits compare as two's-complement signed integers.
  - NaR (MSB=1, rest 0) is treated as below every real value.
  - Strict greater-than replaces the running best, so ties keep the lower index.
  - Element 0 always initialises best.
- On the NB_CLASSES-th transfer, the registered outputs update on the next edge:
  - class_valid_o=1 for one cycle with class_o, class_score_o, pic_idx_o.
  - inflight--, classified++.
  - cls_cnt returns to 0.
- eow check: res_eow_i must be 1 exactly on the NB_CLASSES-th transfer; any mismatch sets err_o. Counting continues by cls_cnt regardless.
- Simultaneous events: a same-cycle admit and classify leaves inflight unchanged.
- Reset mid-job: the block returns to IDLE and drops all counts. Pipeline flushing is the system's responsibility.

Decomposition:
- Package mnist_seq_pkg: state enum (IDLE, RUN, DRAIN, DONE), NaR constant function per POSIT_WIDTH, class index width.
- One sub-module, posit_argmax: a streaming signed-posit max tracker with NaR handling. Its interface is start/valid/data in and idx/score out.

Test Plan:
- cfg_nb_pics=1, source always valid, dn_rtr_i=1: exactly 392 transfers with dn_eow_o on the 392nd only. Output posits 0x1,0x3,0x2,0x7,0x0,0x5,0x7,0x4,0x1,0x0 -> class_o=3, class_score_o=0x7 (tie keeps index 3), pic_idx_o=0, done_o one cycle later.
- cfg_nb_pics=3, MAX_INFLIGHT=2, results withheld: src_rtr_o drops after 784 transfers. Releasing picture 0's results reopens the gate; done_o follows the third class_valid_o.
- Result vector all 0x8 (NaR) except 0xF at index 6 -> class_o=6, class_score_o=0xF.
- res_eow_i asserted on the 5th result -> err_o=1 stays set; classification still fires after the 10th result.
- cfg_nb_pics=0 -> done_o pulses 1 cycle after start with no transfers. cfg_start during RUN has no effect on the count.
- rst=1 on word 200 of picture 0 -> outputs go to 0 next edge. A new start with nb_pics=1 produces eow on exactly the 392nd word.
